seq_addsub_n: RTL and testbench

- Parametrised, multi-cycle ripple adder/subtractor. It processes the operands CHUNK bits per clock, LSB chunk first.
- It is the datapath arithmetic unit for the multi-cycle CPU. It trades latency for a short carry chain per cycle.
- A start/busy/done handshake frames each operation. Results carry status flags (carry, signed overflow, zero).

---
 rtl/seq_addsub_n.sv | 142 ++++++++++++++
 tb/tb_seq_addsub_n.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_n.sv
// seq_addsub_n: multi-cycle ripple adder/subtractor.
// Operands are latched on accept and summed CHUNK bits per clock, LSB chunk first.
// Results and flags appear together with a one-cycle done pulse and hold until the
// next completion or reset. Subtraction is A + ~B + 1, so c_out=1 means no borrow.
module seq_addsub_n #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             c_in,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_addsub_n: WIDTH must be a positive integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [IDXW-1:0]  idx_r;

  int               chunk_lo_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic             msb_carry_in_s;
  logic [WIDTH-1:0] sum_next_s;

  // State register: IDLE/RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: accept in IDLE, return to IDLE after the last chunk.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == IDX_LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // One chunk of ripple addition plus the partial-sum merge for the current index.
  always_comb begin
    chunk_lo_s  = int'(idx_r) * CHUNK;
    a_chunk_s   = a_r[chunk_lo_s +: CHUNK];
    b_chunk_s   = b_r[chunk_lo_s +: CHUNK];
    chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    // Carry into the top bit of this chunk, recovered from the sum bit; only the
    // value seen on the last chunk (carry into the MSB) is used, for overflow.
    msb_carry_in_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
    sum_next_s = sum_r;
    sum_next_s[chunk_lo_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
  end

  // Operand/partial-sum datapath and registered results, flags and handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      S       <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next_s == ST_RUN);
      if (state_r == ST_IDLE) begin
        if (start) begin
          a_r     <= IN1;
          b_r     <= mode ? ~IN2 : IN2;
          carry_r <= mode ? 1'b1 : c_in;
          idx_r   <= '0;
          sum_r   <= '0;
        end else begin
          a_r     <= a_r;
        end
      end else begin
        sum_r   <= sum_next_s;
        carry_r <= chunk_sum_s[CHUNK];
        if (idx_r == IDX_LAST) begin
          idx_r <= '0;
          S     <= sum_next_s;
          c_out <= chunk_sum_s[CHUNK];
          ovf   <= msb_carry_in_s ^ chunk_sum_s[CHUNK];
          zero  <= (sum_next_s == '0);
          done  <= 1'b1;
        end else begin
          idx_r <= idx_r + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub_n.sv
// Self-checking bench for seq_addsub_n: one 32/8 instance plus 8-bit instances with
// CHUNK = 1, 4, 8, checked against an integer-arithmetic reference model.
module tb_seq_addsub_n;

  localparam int WV [4] = '{32, 8, 8, 8};
  localparam int NC [4] = '{4, 8, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  st = 4'b0;
  logic        mode = 1'b0;
  logic        c_in = 1'b0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;

  logic [31:0] s0;
  logic [7:0]  s8 [1:3];
  logic [3:0]  co_v, ov_v, z_v, bz_v, dn_v;

  int nvec = 0;
  int nfail = 0;

  // Expected (held) outputs per instance, maintained by the model.
  logic [31:0] es [4];
  logic        eco [4];
  logic        eov [4];
  logic        ez [4];

  always #5 clk = ~clk;

  seq_addsub_n #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .mode(mode), .IN1(in1), .IN2(in2),
    .c_in(c_in), .S(s0), .c_out(co_v[0]), .ovf(ov_v[0]), .zero(z_v[0]),
    .busy(bz_v[0]), .done(dn_v[0])
  );

  for (genvar g = 1; g <= 3; g++) begin : g_w8
    localparam int CH = (g == 1) ? 1 : ((g == 2) ? 4 : 8);
    seq_addsub_n #(.WIDTH(8), .CHUNK(CH)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(st[g]), .mode(mode), .IN1(in1[7:0]),
      .IN2(in2[7:0]), .c_in(c_in), .S(s8[g]), .c_out(co_v[g]), .ovf(ov_v[g]),
      .zero(z_v[g]), .busy(bz_v[g]), .done(dn_v[g])
    );
  end

  function automatic logic [31:0] got_s(input int i);
    case (i)
      0:       return s0;
      1:       return {24'd0, s8[1]};
      2:       return {24'd0, s8[2]};
      default: return {24'd0, s8[3]};
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic m, input logic ci, output logic [31:0] s,
                                output logic co, output logic ov, output logic z);
    longint msk  = (64'sd1 <<< w) - 64'sd1;
    longint half = 64'sd1 <<< (w - 1);
    longint ua = longint'(a) & msk;
    longint ub = longint'(b) & msk;
    longint sa = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
    longint sb = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
    longint full, sr;
    if (!m) begin
      full = ua + ub + longint'(ci);
      co   = (full > msk);
      sr   = sa + sb + longint'(ci);
    end else begin
      full = ua - ub;
      co   = (ua >= ub);
      sr   = sa - sb;
    end
    s  = 32'(full & msk);
    ov = (sr < -half) || (sr > half - 64'sd1);
    z  = (s == 32'd0);
  endfunction

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      es[i] = 32'd0; eco[i] = 1'b0; eov[i] = 1'b0; ez[i] = 1'b0;
    end
  endtask

  task automatic chk_reset_state();
    for (int i = 0; i < 4; i++) begin
      chk("rst_s", i, got_s(i), 32'd0);
      chk("rst_flags", i, {co_v[i], ov_v[i], z_v[i]}, 3'b000);
      chk("rst_busy", i, bz_v[i], 1'b0);
      chk("rst_done", i, dn_v[i], 1'b0);
    end
  endtask

  // Start one operation on the enabled instances and follow it edge by edge.
  // Returns in the done cycle of the slowest enabled instance.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic ci, input logic [3:0] en, input bit mid);
    logic [31:0] ns [4];
    logic        nco [4], nov [4], nz [4];
    int jmax = 0;
    for (int i = 0; i < 4; i++) begin
      model(WV[i], a, b, m, ci, ns[i], nco[i], nov[i], nz[i]);
      if (en[i] && NC[i] > jmax) jmax = NC[i];
    end
    in1 = a; in2 = b; mode = m; c_in = ci; st = en;
    @(posedge clk); #1;
    st = 4'b0; in1 = $urandom; in2 = $urandom;
    mode = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
    for (int j = 0; j <= jmax; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        if (en[i]) begin
          if (j < NC[i]) begin
            chk("busy_run", i, bz_v[i], 1'b1);
            chk("done_early", i, dn_v[i], 1'b0);
            chk("s_hold", i, got_s(i), es[i]);
            chk("c_hold", i, co_v[i], eco[i]);
          end else if (j == NC[i]) begin
            es[i] = ns[i]; eco[i] = nco[i]; eov[i] = nov[i]; ez[i] = nz[i];
            chk("done", i, dn_v[i], 1'b1);
            chk("busy_end", i, bz_v[i], 1'b0);
            chk("S", i, got_s(i), es[i]);
            chk("c_out", i, co_v[i], eco[i]);
            chk("ovf", i, ov_v[i], eov[i]);
            chk("zero", i, z_v[i], ez[i]);
          end else begin
            chk("done_pulse", i, dn_v[i], 1'b0);
            chk("busy_idle", i, bz_v[i], 1'b0);
          end
        end
      end
      if (mid && j == 1) begin
        st = en; in1 = $urandom; in2 = $urandom;
      end else if (mid && j == 2) begin
        st = 4'b0;
      end
    end
  endtask

  task automatic chk_idle_tail(input logic [3:0] en);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        chk("tail_done", i, dn_v[i], 1'b0);
        chk("tail_busy", i, bz_v[i], 1'b0);
        chk("tail_s", i, got_s(i), es[i]);
      end
    end
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset_state();

    // Directed arithmetic cases on all instances.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'b1111, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'b1111, 1'b0);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 4'b1111, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 4'b1111, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 4'b1111, 1'b0);
    run_op(32'h0000_0009, 32'h0000_0009, 1'b1, 1'b1, 4'b1111, 1'b0);
    run_op(32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0, 4'b1111, 1'b0);
    chk_idle_tail(4'b1111);

    // start pulsed mid-RUN must be ignored.
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'b0001, 1'b1);
    chk_idle_tail(4'b0001);

    // Back-to-back: second start issued in the done cycle.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4'b0001, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 4'b0001, 1'b0);
    chk_idle_tail(4'b0001);

    // Reset in the middle of an operation (idx = 2).
    in1 = 32'hAAAA_5555; in2 = 32'h1234_4321; mode = 1'b0; c_in = 1'b1; st = 4'b0001;
    @(posedge clk); #1;
    st = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    chk_reset_state();
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", 0, dn_v[0], 1'b0);
    end
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 4'b1111, 1'b0);

    // Randomized operands on every instance.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (n % 8 == 0) ? ra : 32'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'b1111, 1'b0);
    end
    chk_idle_tail(4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
